// File: rtl/lcd_rd_pkg.sv
// lcd_rd_pkg: shared state encoding, flush length and frame-size helper for the LCD read scheduler.
`default_nettype none

package lcd_rd_pkg;

  localparam int FLUSH_CYC = 4;
  localparam int RD_LEN_W  = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_CHECK = 3'd2,
    ST_REQ   = 3'd3,
    ST_BURST = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Frame size rounded up to a whole number of bursts.
  function automatic int unsigned frame_aligned(input int unsigned words, input int unsigned burst);
    return ((words + burst - 1) / burst) * burst;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_rd_sched_if.sv
// lcd_rd_sched_if: SDRAM controller read-port handshake between the scheduler (master) and controller (slave).
`default_nettype none

interface lcd_rd_sched_if #(
  parameter int ADDR_W = 24
) ();
  import lcd_rd_pkg::*;

  logic                rd_req;
  logic [ADDR_W-1:0]   rd_addr;
  logic [RD_LEN_W-1:0] rd_len;
  logic                rd_ack;
  logic                rd_done;

  modport master (
    output rd_req, rd_addr, rd_len,
    input  rd_ack, rd_done
  );

  modport slave (
    input  rd_req, rd_addr, rd_len,
    output rd_ack, rd_done
  );

endinterface

`default_nettype wire

// File: rtl/lcd_rd_addr_gen.sv
// lcd_rd_addr_gen: burst address and remaining-word counters; load has priority over step.
`default_nettype none

module lcd_rd_addr_gen #(
  parameter int          ADDR_W        = 24,
  parameter int          BURST_LEN     = 256,
  parameter int unsigned FRAME_ALIGNED = 307200
) (
  input  logic              lcd_pclk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last_burst
);

  localparam logic [ADDR_W-1:0] STEP_W  = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] FRAME_W = ADDR_W'(FRAME_ALIGNED);

  logic [ADDR_W-1:0] words_left;

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      words_left <= '0;
    end else if (load) begin
      addr       <= base;
      words_left <= FRAME_W;
    end else if (step) begin
      addr       <= addr + STEP_W;
      words_left <= words_left - STEP_W;
    end
  end

  assign last_burst = (words_left == STEP_W);

endmodule

`default_nettype wire

// File: rtl/lcd_rd_sched.sv
// lcd_rd_sched: per-frame SDRAM read scheduler in the LCD pixel clock domain.
// Define LCD_RD_PINGPONG_EN for two frame buffers swapped on frame_wr_done; otherwise buffer 0 only.
`default_nettype none

module lcd_rd_sched
  import lcd_rd_pkg::*;
#(
  parameter int                BURST_LEN   = 256,
  parameter int                FRAME_WORDS = 307200,
  parameter int                FIFO_DEPTH  = 1024,
  parameter int                ADDR_W      = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR0  = '0,
  parameter logic [ADDR_W-1:0] BASE_ADDR1  = 24'h080000
) (
  input  logic                lcd_pclk,
  input  logic                rst_n,
  input  logic                lcd_vs,
  input  logic                data_req,
  input  logic                fifo_empty,
  input  logic [10:0]         fifo_wrusedw,
  input  logic                frame_wr_done,
  lcd_rd_sched_if.master      rd,
  output logic                fifo_flush,
  output logic                active_buf,
  output logic                underrun,
  output logic [7:0]          ovr_cnt
);

  localparam int unsigned FRAME_ALIGNED = frame_aligned(FRAME_WORDS, BURST_LEN);
  localparam logic [31:0] SPACE_LIM     = 32'(FIFO_DEPTH - BURST_LEN);
  localparam int          FC_W          = $clog2(FLUSH_CYC);

  state_t            state, next_state;
  logic              vs_d, vs_rise;
  logic [FC_W-1:0]   flush_cnt;
  logic              abort_pend, fetched;
  logic              flush_entry, do_step, ovr_inc, abort_set;
  logic              next_buf, has_space, last_burst;
  logic [ADDR_W-1:0] addr, load_base;

  assign vs_rise     = lcd_vs & ~vs_d;
  assign has_space   = (32'(fifo_wrusedw) <= SPACE_LIM);
  assign flush_entry = (next_state == ST_FLUSH) && (state != ST_FLUSH);
  assign load_base   = next_buf ? BASE_ADDR1 : BASE_ADDR0;
  assign rd.rd_len   = RD_LEN_W'(BURST_LEN);

  always_comb begin
    next_state = state;
    do_step    = 1'b0;
    ovr_inc    = 1'b0;
    abort_set  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (vs_rise) next_state = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (flush_cnt == FC_W'(FLUSH_CYC - 1)) next_state = ST_CHECK;
      end
      ST_CHECK: begin
        if (vs_rise) begin
          next_state = ST_FLUSH;
          ovr_inc    = ~fetched;
        end else if (fetched) begin
          next_state = ST_DONE;
        end else if (has_space) begin
          next_state = ST_REQ;
        end
      end
      ST_REQ: begin
        // An accepted request must run to rd_done before the restart.
        if (rd.rd_ack) begin
          next_state = ST_BURST;
          abort_set  = vs_rise;
        end else if (vs_rise) begin
          next_state = ST_FLUSH;
          ovr_inc    = 1'b1;
        end
      end
      ST_BURST: begin
        if (rd.rd_done) begin
          do_step = 1'b1;
          if (abort_pend || vs_rise) begin
            next_state = ST_FLUSH;
            ovr_inc    = 1'b1;
          end else begin
            next_state = ST_CHECK;
          end
        end else begin
          abort_set = vs_rise;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      vs_d       <= 1'b0;
      flush_cnt  <= '0;
      abort_pend <= 1'b0;
      fetched    <= 1'b0;
      fifo_flush <= 1'b0;
      rd.rd_req  <= 1'b0;
      rd.rd_addr <= BASE_ADDR0;
      underrun   <= 1'b0;
      ovr_cnt    <= '0;
    end else begin
      state      <= next_state;
      vs_d       <= lcd_vs;
      fifo_flush <= (next_state == ST_FLUSH);
      rd.rd_req  <= (next_state == ST_REQ);
      if (next_state == ST_REQ && state != ST_REQ) rd.rd_addr <= addr;

      if (flush_entry)               flush_cnt <= '0;
      else if (state == ST_FLUSH)    flush_cnt <= flush_cnt + 1'b1;

      if (flush_entry)               abort_pend <= 1'b0;
      else if (abort_set)            abort_pend <= 1'b1;

      // Set when the final burst lands: equivalent to words_left reaching zero.
      if (flush_entry)               fetched <= 1'b0;
      else if (do_step && last_burst) fetched <= 1'b1;

      if (flush_entry)               underrun <= 1'b0;
      else if (state != ST_FLUSH && data_req && fifo_empty) underrun <= 1'b1;

      if (ovr_inc && ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
    end
  end

`ifdef LCD_RD_PINGPONG_EN
  logic pend_buf;

  // A completion arriving on the vsync cycle is taken by this same flush.
  assign next_buf = active_buf ^ (pend_buf | frame_wr_done);

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      active_buf <= 1'b0;
      pend_buf   <= 1'b0;
    end else if (flush_entry) begin
      active_buf <= next_buf;
      pend_buf   <= 1'b0;
    end else if (frame_wr_done) begin
      pend_buf   <= 1'b1;
    end
  end
`else
  logic unused_frame_wr_done;

  assign unused_frame_wr_done = frame_wr_done;
  assign next_buf             = 1'b0;
  assign active_buf           = 1'b0;
`endif

  lcd_rd_addr_gen #(
    .ADDR_W        (ADDR_W),
    .BURST_LEN     (BURST_LEN),
    .FRAME_ALIGNED (FRAME_ALIGNED)
  ) u_addr_gen (
    .lcd_pclk   (lcd_pclk),
    .rst_n      (rst_n),
    .load       (flush_entry),
    .base       (load_base),
    .step       (do_step),
    .addr       (addr),
    .last_burst (last_burst)
  );

endmodule

`default_nettype wire
